// File: rtl/mem_uart_responder.sv
// Byte-framed memory/print command responder behind a UART.
// Ports: rx/tx byte streams, 32-bit memory request bus, print strobe, halt.
module mem_uart_responder #(
  parameter int CLK     = 25,
  parameter int TIMEOUT = 50
) (
  input  logic        clk,
  input  logic        res,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [7:0]  print_data,
  output logic        print_valid,
  output logic        halted,
  output logic        rx_drop
);

  localparam int ABORT_CYCLES = CLK * 1000 * TIMEOUT;
  localparam int TW = $clog2(ABORT_CYCLES + 1);

  localparam logic [7:0] C_READ  = 8'h01;
  localparam logic [7:0] C_WRITE = 8'h02;
  localparam logic [7:0] C_PRINT = 8'h03;
  localparam logic [7:0] C_HLT   = 8'h04;

  typedef enum logic [2:0] {
    S_CMD, S_ARGS, S_MEM, S_REPLY, S_HALT
  } state_t;

  state_t state, state_n;

  logic [7:0]    cmd;
  logic [3:0]    cnt;
  logic [TW-1:0] tmo;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  logic       cmd_ok;
  logic [3:0] nargs;
  logic       last_arg;
  logic       tmo_hit;

  always_comb begin
    cmd_ok = (rx_data >= C_READ) && (rx_data <= C_HLT);
    nargs  = 4'd1;
    unique case (1'b1)
      (cmd == C_READ):  nargs = 4'd4;
      (cmd == C_WRITE): nargs = 4'd8;
      default:          nargs = 4'd1;
    endcase
    last_arg = (cnt == nargs - 4'd1);
    tmo_hit  = (tmo == TW'(ABORT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (res) state <= S_CMD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_CMD: begin
        if (rx_valid && cmd_ok)
          state_n = (rx_data == C_HLT) ? S_HALT : S_ARGS;
      end
      S_ARGS: begin
        if (rx_valid) begin
          if (last_arg)
            state_n = (cmd == C_PRINT) ? S_CMD : S_MEM;
        end else if (tmo_hit) begin
          state_n = S_CMD;
        end
      end
      S_MEM: begin
        if (mem_ready)
          state_n = (cmd == C_READ) ? S_REPLY : S_CMD;
      end
      S_REPLY: begin
        if (tx_ready && cnt[1:0] == 2'd3)
          state_n = S_CMD;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_CMD;
    endcase
  end

  // Requests and reply are decoded from state so that a reset
  // drops them on the very edge it is sampled.
  always_comb begin
    mem_re    = (state == S_MEM) && (cmd == C_READ);
    mem_we    = (state == S_MEM) && (cmd == C_WRITE);
    mem_addr  = addr;
    mem_wdata = wdata;
    tx_valid  = (state == S_REPLY);
    tx_data   = 8'h00;
    if (tx_valid)
      tx_data = rdata[{cnt[1:0], 3'b000} +: 8];
    halted    = (state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cmd         <= 8'h00;
      cnt         <= 4'd0;
      tmo         <= '0;
      addr        <= 32'h0;
      wdata       <= 32'h0;
      rdata       <= 32'h0;
      print_data  <= 8'h00;
      print_valid <= 1'b0;
      rx_drop     <= 1'b0;
    end else begin
      print_valid <= 1'b0;
      rx_drop     <= 1'b0;
      case (state)
        S_CMD: begin
          if (rx_valid) begin
            if (cmd_ok) begin
              cmd <= rx_data;
              cnt <= 4'd0;
              tmo <= '0;
            end else begin
              rx_drop <= 1'b1;
            end
          end
        end
        S_ARGS: begin
          if (rx_valid) begin
            tmo <= '0;
            if (cmd == C_PRINT) begin
              print_data  <= rx_data;
              print_valid <= 1'b1;
            end else if (!cnt[2]) begin
              addr[{cnt[1:0], 3'b000} +: 8] <= rx_data;
            end else begin
              wdata[{cnt[1:0], 3'b000} +: 8] <= rx_data;
            end
            if (!last_arg)
              cnt <= cnt + 4'd1;
          end else if (!tmo_hit) begin
            tmo <= tmo + TW'(1);
          end
        end
        S_MEM: begin
          if (rx_valid)
            rx_drop <= 1'b1;
          if (mem_ready && cmd == C_READ) begin
            rdata <= mem_rdata;
            cnt   <= 4'd0;
          end
        end
        S_REPLY: begin
          if (rx_valid)
            rx_drop <= 1'b1;
          if (tx_ready && cnt[1:0] != 2'd3)
            cnt <= cnt + 4'd1;
        end
        S_HALT: begin
          if (rx_valid)
            rx_drop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_uart_responder.sv
// Directed bench for mem_uart_responder.
// Small timeout (CLK=1, TIMEOUT=1 -> 1000 cycles) keeps runs short.
module tb_mem_uart_responder;

  logic        clk = 1'b0;
  logic        res;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [7:0]  print_data;
  logic        print_valid;
  logic        halted;
  logic        rx_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_uart_responder #(.CLK(1), .TIMEOUT(1)) dut (
    .clk(clk), .res(res),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .print_data(print_data),
    .print_valid(print_valid),
    .halted(halted), .rx_drop(rx_drop)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] c,
                       input logic [31:0] a);
    send(c);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = a >> (8 * i);
      send(t[7:0]);
    end
  endtask

  initial begin
    logic [7:0]  exp_b [4];
    logic [31:0] w;
    int          re_cnt;
    logic        ok;
    logic        drop_seen;

    res = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    tx_ready = 1'b0; mem_rdata = 32'h0; mem_ready = 1'b0;
    tick(); tick();
    res = 1'b0;
    chk("rst_txv",   {31'h0, tx_valid}, 32'h0);
    chk("rst_re",    {31'h0, mem_re}, 32'h0);
    chk("rst_we",    {31'h0, mem_we}, 32'h0);
    chk("rst_halt",  {31'h0, halted}, 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);

    // READ 0x10 -> DEADBEEF, ready after 3 wait cycles
    send5(8'h01, 32'h10);
    chk("rd_addr", mem_addr, 32'h10);
    chk("rd_we",   {31'h0, mem_we}, 32'h0);
    re_cnt = 0;
    repeat (3) begin
      if (mem_re) re_cnt++;
      tick();
    end
    mem_rdata = 32'hDEADBEEF;
    mem_ready = 1'b1;
    if (mem_re) re_cnt++;
    tick();
    mem_ready = 1'b0;
    chk("rd_re_cycles", re_cnt, 4);
    chk("rd_re_off", {31'h0, mem_re}, 32'h0);
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rd_txv", {31'h0, tx_valid}, 32'h1);
      chk("rd_txd", {24'h0, tx_data}, {24'h0, exp_b[i]});
      tick();
    end
    tx_ready = 1'b0;
    chk("rd_txv_end", {31'h0, tx_valid}, 32'h0);

    // WRITE 0x4 <- 0x12345678
    send5(8'h02, 32'h4);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    chk("wr_we",    {31'h0, mem_we}, 32'h1);
    chk("wr_re",    {31'h0, mem_re}, 32'h0);
    chk("wr_addr",  mem_addr, 32'h4);
    chk("wr_wdata", mem_wdata, 32'h12345678);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("wr_we_off", {31'h0, mem_we}, 32'h0);
    ok = 1'b1;
    repeat (3) begin
      if (tx_valid) ok = 1'b0;
      tick();
    end
    chk("wr_no_tx", {31'h0, ok}, 32'h1);

    // PRINT 'A', HLT back-to-back, then READ bytes dropped
    send(8'h03);
    send(8'h41);
    chk("pr_valid", {31'h0, print_valid}, 32'h1);
    chk("pr_data",  {24'h0, print_data}, 32'h41);
    send(8'h04);
    chk("pr_pulse", {31'h0, print_valid}, 32'h0);
    chk("hlt",      {31'h0, halted}, 32'h1);
    w = 32'h10;
    for (int i = 0; i < 5; i++) begin
      send(i == 0 ? 8'h01 : 8'h00);
      chk("hlt_drop", {31'h0, rx_drop}, 32'h1);
      chk("hlt_re",   {31'h0, mem_re}, 32'h0);
    end
    chk("hlt_hold", {31'h0, halted}, 32'h1);
    res = 1'b1; tick(); res = 1'b0;
    chk("hlt_clr", {31'h0, halted}, 32'h0);

    // Partial frame, silence, then full READ 0x20
    send(8'h01); send(8'h10); send(8'h00);
    repeat (1000) tick();
    send5(8'h01, 32'h20);
    chk("to_addr", mem_addr, 32'h20);
    re_cnt = 0;
    mem_rdata = 32'h0;
    mem_ready = 1'b1;
    if (mem_re) re_cnt++;
    tick();
    mem_ready = 1'b0;
    if (mem_re) re_cnt++;
    chk("to_re_once", re_cnt, 1);
    tx_ready = 1'b1;
    repeat (4) tick();
    tx_ready = 1'b0;
    chk("to_done", {31'h0, tx_valid}, 32'h0);

    // Back-pressure on reply, extra rx byte mid-reply
    send5(8'h01, 32'h30);
    mem_rdata = 32'h11223344;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    drop_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b1;
      for (int j = 0; j < 5; j++) begin
        if (!(tx_valid && tx_data == exp_b[i])) ok = 1'b0;
        if (i == 1 && j == 2) begin
          rx_data = 8'h01;
          rx_valid = 1'b1;
        end
        tick();
        if (i == 1 && j == 2) drop_seen = rx_drop;
        rx_valid = 1'b0;
      end
      chk("bp_hold", {31'h0, ok}, 32'h1);
      tx_ready = 1'b1;
      chk("bp_byte", {24'h0, tx_data}, {24'h0, exp_b[i]});
      tick();
      tx_ready = 1'b0;
    end
    chk("bp_drop", {31'h0, drop_seen}, 32'h1);
    chk("bp_end",  {31'h0, tx_valid}, 32'h0);

    // Invalid command, then reset mid-reply
    send(8'h07);
    chk("inv_drop", {31'h0, rx_drop}, 32'h1);
    chk("inv_re",   {31'h0, mem_re}, 32'h0);
    send5(8'h01, 32'h40);
    mem_rdata = 32'hCAFEF00D;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("mid_txd", {24'h0, tx_data}, 32'hF0);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("rr_txv",  {31'h0, tx_valid}, 32'h0);
    chk("rr_txd",  {24'h0, tx_data}, 32'h0);
    chk("rr_re",   {31'h0, mem_re}, 32'h0);
    chk("rr_we",   {31'h0, mem_we}, 32'h0);
    chk("rr_addr", mem_addr, 32'h0);
    chk("rr_wd",   mem_wdata, 32'h0);
    chk("rr_pd",   {24'h0, print_data}, 32'h0);
    chk("rr_pv",   {31'h0, print_valid}, 32'h0);
    chk("rr_drop", {31'h0, rx_drop}, 32'h0);
    chk("rr_halt", {31'h0, halted}, 32'h0);
    tx_ready = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      if (tx_valid) ok = 1'b0;
      tick();
    end
    tx_ready = 1'b0;
    chk("rr_quiet", {31'h0, ok}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
